// File: rtl/color_entry_pkg.sv
// color_entry_pkg: shared state, key and setpoint encodings for the keypad entry sequencer.
package color_entry_pkg;
   localparam logic [1:0] SEL_R = 2'd0, SEL_G = 2'd1, SEL_B = 2'd2, SEL_DONE = 2'd3;
   typedef enum logic [1:0] {S_R = SEL_R, S_G = SEL_G, S_B = SEL_B, S_DONE = SEL_DONE} state_t;
   localparam logic [3:0] KEY_OK = 4'hA, KEY_CLR = 4'hC;
   localparam logic [4:0] VAL_UNSET = 5'd16;
endpackage

// File: rtl/entry_timeout.sv
// entry_timeout: idle counter; expire pulses when armed and un-kicked for TIMEOUT_CYC cycles.
module entry_timeout #(
   parameter int TIMEOUT_CYC = 50_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic kick,
   input  logic arm,
   output logic expire
);
   localparam int W = TIMEOUT_CYC > 2 ? $clog2(TIMEOUT_CYC) : 1;
   logic [W-1:0] cnt;
   assign expire = arm && !kick && cnt == W'(TIMEOUT_CYC - 1);
   always_ff @(posedge clk) begin
      if (rst || kick || !arm || expire) cnt <= '0;
      else cnt <= cnt + 1'b1;
   end
endmodule

// File: rtl/color_entry.sv
// color_entry: keypad R/G/B setpoint sequencer feeding the dispense timer.
// Optional idle abort enabled by defining ENTRY_TIMEOUT_EN.
module color_entry
   import color_entry_pkg::*;
#(
   parameter int VAL_MAX     = 15,
   parameter int TIMEOUT_CYC = 50_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   output logic [4:0] R,
   output logic [4:0] G,
   output logic [4:0] B,
   output logic       enter,
   output logic [1:0] sel,
   output logic       err
);
   state_t state, state_n;
   logic [4:0] acc, acc_n, r_pend, r_pend_n, g_pend, g_pend_n;
   logic [1:0] ndig, ndig_n;
   logic [7:0] sum;
   logic err_n, commit, clear, expire, enter_pend;
   assign sel = state;
   assign sum = 8'(acc) * 8'd10 + 8'(key_code);
`ifdef ENTRY_TIMEOUT_EN
   entry_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
      .clk(clk), .rst(rst), .kick(key_valid),
      .arm(state != S_DONE && (ndig != 2'd0 || state != S_R)),
      .expire(expire)
   );
`else
   assign expire = TIMEOUT_CYC < 0;
`endif
   assign clear = expire || (key_valid && key_code == KEY_CLR);
   always_comb begin
      state_n  = state;
      acc_n    = acc;
      ndig_n   = ndig;
      r_pend_n = r_pend;
      g_pend_n = g_pend;
      commit   = 1'b0;
      err_n    = 1'b0;
      if (clear) begin
         state_n  = S_R;
         acc_n    = '0;
         ndig_n   = '0;
         r_pend_n = '0;
         g_pend_n = '0;
         err_n    = expire;
      end else if (key_valid && state != S_DONE) begin
         if (key_code <= 4'd9) begin
            if (ndig == 2'd0) begin
               acc_n  = 5'(key_code);
               ndig_n = 2'd1;
            end else if (ndig == 2'd1) begin
               acc_n  = int'(sum) <= VAL_MAX ? sum[4:0] : 5'd0;
               ndig_n = int'(sum) <= VAL_MAX ? 2'd2 : 2'd0;
               err_n  = int'(sum) > VAL_MAX;
            end else err_n = 1'b1;
         end else if (key_code == KEY_OK) begin
            if (ndig == 2'd0) err_n = 1'b1;
            else begin
               acc_n    = '0;
               ndig_n   = '0;
               r_pend_n = state == S_R ? acc : r_pend;
               g_pend_n = state == S_G ? acc : g_pend;
               commit   = state == S_B;
               state_n  = state == S_R ? S_G : state == S_G ? S_B : S_DONE;
            end
         end else err_n = 1'b1;
      end
   end
   // enter is delayed one extra cycle so R/G/B are stable a full cycle before start
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_R;
         acc        <= '0;
         ndig       <= '0;
         r_pend     <= '0;
         g_pend     <= '0;
         R          <= VAL_UNSET;
         G          <= VAL_UNSET;
         B          <= VAL_UNSET;
         err        <= 1'b0;
         enter      <= 1'b0;
         enter_pend <= 1'b0;
      end else begin
         state      <= state_n;
         acc        <= acc_n;
         ndig       <= ndig_n;
         r_pend     <= r_pend_n;
         g_pend     <= g_pend_n;
         err        <= err_n;
         enter_pend <= commit;
         enter      <= enter_pend && !clear;
         if (clear) begin
            R <= VAL_UNSET;
            G <= VAL_UNSET;
            B <= VAL_UNSET;
         end else if (commit) begin
            R <= r_pend;
            G <= g_pend;
            B <= acc;
         end
      end
   end
endmodule
